// File: rtl/rot_pkg.sv
// Shared definitions for the rotate feeder: default word geometry, word/amount
// types and the completed-output counter width.
package rot_pkg;

    localparam int N_DEFAULT      = 32;
    localparam int LOG2_N_DEFAULT = 5;
    localparam int COUNT_W        = 16;

    typedef logic [0:N_DEFAULT-1]      word_t;
    typedef logic [0:LOG2_N_DEFAULT-1] amt_t;
    typedef logic [COUNT_W-1:0]        count_t;

endpackage

// File: rtl/rot_feeder_rot.sv
// Combinational rotator: out_bits[j] = in_bits[(j - K) mod N], index 0 is the MSB.
// Built as a log2(N)-stage barrel, stage s rotating by N >> (s+1) when in_k[s] is set.
module rot #(
    parameter int N      = 32,
    parameter int log2_N = 5
) (
    input  logic [0:N-1]      in_bits,
    input  logic [0:log2_N-1] in_k,
    output logic [0:N-1]      out_bits
);

    // With [0:N-1] ordering a right shift moves bits toward higher indices,
    // which is exactly the out[j] = in[j - w] direction.
    function automatic logic [0:N-1] rotr(input logic [0:N-1] x, input int w);
        return (x >> w) | (x << (N - w));
    endfunction

    logic [0:N-1] acc;

    always_comb begin
        acc = in_bits;
        for (int s = 0; s < log2_N; s++) begin
            if (in_k[s]) begin
                acc = rotr(acc, N >> (s + 1));
            end
        end
        out_bits = acc;
    end

endmodule

// File: rtl/rot_feeder.sv
// Rotate feeder: 2-entry input FIFO -> rot -> output register, valid/ready on both sides.
// Optional completed-output counter (out_count) enabled by defining ROT_FEEDER_COUNT_EN.
module rot_feeder
    import rot_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int log2_N = LOG2_N_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; valid holds its payload until then, ready never depends on valid.
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:N-1]      in_bits,
    input  logic [0:log2_N-1] in_k,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:N-1]      out_bits
`ifdef ROT_FEEDER_COUNT_EN
    ,
    output logic [COUNT_W-1:0] out_count
`endif
);

    logic [0:N-1]      mem_bits_q [0:1];
    logic [0:N-1]      mem_bits_d [0:1];
    logic [0:log2_N-1] mem_k_q    [0:1];
    logic [0:log2_N-1] mem_k_d    [0:1];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [0:N-1]      out_bits_q, out_bits_d;

    logic              push;
    logic              pop;
    logic              out_fire;
    logic [0:N-1]      head_bits;
    logic [0:log2_N-1] head_k;
    logic [0:N-1]      rot_bits;

    assign head_bits = mem_bits_q[rd_ptr_q];
    assign head_k    = mem_k_q[rd_ptr_q];

    rot #(
        .N      (N),
        .log2_N (log2_N)
    ) u_rot (
        .in_bits  (head_bits),
        .in_k     (head_k),
        .out_bits (rot_bits)
    );

    always_comb begin
        push     = in_valid & in_ready_q;
        out_fire = out_valid_q & out_ready;
        // The output register only reads the FIFO head, so a word written into
        // an empty FIFO reaches the output one cycle later.
        pop      = (count_q != 2'd0) & (~out_valid_q | out_ready);

        mem_bits_d = mem_bits_q;
        mem_k_d    = mem_k_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            mem_bits_d[wr_ptr_q] = in_bits;
            mem_k_d[wr_ptr_q]    = in_k;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        in_ready_d = (count_d != 2'd2);

        out_valid_d = out_valid_q;
        out_bits_d  = out_bits_q;
        if (pop) begin
            out_valid_d = 1'b1;
            out_bits_d  = rot_bits;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_bits_q[i] <= '0;
                mem_k_q[i]    <= '0;
            end
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
        end else begin
            mem_bits_q  <= mem_bits_d;
            mem_k_q     <= mem_k_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bits  = out_bits_q;

`ifdef ROT_FEEDER_COUNT_EN
    logic [COUNT_W-1:0] out_count_q, out_count_d;

    always_comb begin
        out_count_d = out_count_q;
        if (out_fire && (out_count_q != {COUNT_W{1'b1}})) begin
            out_count_d = out_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count_q <= '0;
        end else begin
            out_count_q <= out_count_d;
        end
    end

    assign out_count = out_count_q;
`endif

endmodule

// File: tb/tb_rot_feeder.sv
// Bench for rot_feeder: directed vectors plus a queue-based reference model
// checked against the DUT on every negative clock edge.
module tb_rot_feeder;

    localparam int N  = 32;
    localparam int LN = 5;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [0:N-1]  in_bits   = '0;
    logic [0:LN-1] in_k      = '0;
    logic          in_ready;
    logic          out_valid;
    logic [0:N-1]  out_bits;
`ifdef ROT_FEEDER_COUNT_EN
    logic [15:0]   out_count;
`endif

    rot_feeder #(.N(N), .log2_N(LN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .in_k      (in_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits)
`ifdef ROT_FEEDER_COUNT_EN
        ,
        .out_count (out_count)
`endif
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    int          out_cyc[$];
    int          n_out    = 0;
    int          cyc      = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] bits_prev  = '0;
    logic [31:0] e;
    logic        drv_done = 1'b0;
    int          w_a, w_b, w_c, w_tot, base_n, base_c, w_tmp;

    // Reference rotation straight from the definition out[j] = in[(j-K) mod N].
    function automatic logic [31:0] ref_rot(input logic [0:31] b, input int k);
        logic [0:31] r;
        for (int j = 0; j < 32; j++) begin
            r[j] = b[(j - k + 32) % 32];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and return after the edge that accepts it.
    task automatic push_word(input logic [31:0] bits, input logic [4:0] k, output int waited);
        logic acc;
        in_valid = 1'b1;
        in_bits  = bits;
        in_k     = k;
        waited   = 0;
        acc      = 1'b0;
        while (!acc && waited < 200) begin
            acc = in_ready;
            step();
            waited++;
        end
        if (!acc) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 400) begin
            step();
            t++;
        end
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    task automatic single_word(input logic [31:0] bits, input logic [4:0] k, input logic [31:0] req);
        out_ready = 1'b1;
        push_word(bits, k, w_tmp);
        in_valid = 1'b0;
        chk("lat_not_yet", out_valid, 32'd0);
        step();
        chk("lat_valid", out_valid, 32'd1);
        chk("lat_bits", out_bits, req);
        step();
        chk("lat_gone", out_valid, 32'd0);
    endtask

    // Scoreboard: record accepted words, compare every output transfer in order.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            n_out      = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", out_valid, 32'd1);
                chk("hold_stable", out_bits, bits_prev);
            end
`ifdef ROT_FEEDER_COUNT_EN
            chk("out_count_model", out_count, (n_out > 65535) ? 32'd65535 : n_out);
`endif
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_output got=%h required=none", out_bits);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_data", out_bits, e);
                end
                n_out++;
                out_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_rot(in_bits, int'(in_k)));
            end
            stall_prev = out_valid && !out_ready;
            bits_prev  = out_bits;
        end
    end

    initial begin
        // Reset state and in_ready rising on the first edge after release.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 32'd0);
        chk("rst_in_ready", in_ready, 32'd0);
        chk("rst_out_bits", out_bits, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_low", in_ready, 32'd0);
        step();
        chk("rel_in_ready_rise", in_ready, 32'd1);

        // Pin the reference model to hand-computed values.
        chk("model_k1", ref_rot(32'h8000_0000, 1), 32'h4000_0000);
        chk("model_k31", ref_rot(32'h8000_0000, 31), 32'h0000_0001);
        chk("model_k4", ref_rot(32'h1234_5678, 4), 32'h8123_4567);
        chk("model_k16", ref_rot(32'hDEAD_BEEF, 16), 32'hBEEF_DEAD);

        // Single words with latency.
        single_word(32'h8000_0000, 5'd1, 32'h4000_0000);
        single_word(32'h8000_0000, 5'd31, 32'h0000_0001);
        single_word(32'h8000_0000, 5'd0, 32'h8000_0000);
        single_word(32'h1234_5678, 5'd4, 32'h8123_4567);
        single_word(32'hDEAD_BEEF, 5'd16, 32'hBEEF_DEAD);

        // Backpressure: three words with out_ready low.
        out_ready = 1'b0;
        push_word(32'h0000_0001, 5'd1, w_a);
        push_word(32'hF000_0000, 5'd4, w_b);
        push_word(32'h0000_0003, 5'd2, w_c);
        in_valid = 1'b0;
        chk("bp_acc_a", w_a, 32'd1);
        chk("bp_acc_b", w_b, 32'd1);
        chk("bp_acc_c", w_c, 32'd1);
        chk("bp_in_ready_low", in_ready, 32'd0);
        chk("bp_out_valid", out_valid, 32'd1);
        chk("bp_bits_a", out_bits, 32'h8000_0000);
        repeat (3) step();
        chk("bp_bits_a_held", out_bits, 32'h8000_0000);
        out_ready = 1'b1;
        step();
        chk("bp_order_b", out_bits, 32'h0F00_0000);
        step();
        chk("bp_order_c", out_bits, 32'hC000_0000);
        step();
        chk("bp_done", out_valid, 32'd0);

        // Reset mid-stream with words buffered.
        out_ready = 1'b0;
        push_word(32'hAAAA_0001, 5'd3, w_tmp);
        push_word(32'h5555_0002, 5'd7, w_tmp);
        push_word(32'h1111_0003, 5'd9, w_tmp);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 32'd0);
        chk("mid_rst_in_ready", in_ready, 32'd0);
        chk("mid_rst_out_bits", out_bits, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        chk("mid_rel_in_ready_low", in_ready, 32'd0);
        step();
        chk("mid_rel_in_ready_rise", in_ready, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("no_stale", out_valid, 32'd0);
            step();
        end
`ifdef ROT_FEEDER_COUNT_EN
        chk("mid_rst_count", out_count, 32'd0);
`endif

        // Streaming: 100 words back to back.
        out_ready = 1'b1;
        base_n = n_out;
        base_c = out_cyc.size();
        w_tot  = 0;
        for (int i = 0; i < 100; i++) begin
            push_word($urandom(), 5'($urandom_range(0, 31)), w_tmp);
            w_tot += w_tmp;
        end
        in_valid = 1'b0;
        chk("stream_in_no_bubble", w_tot, 32'd100);
        drain();
        chk("stream_count", n_out - base_n, 32'd100);
        if (out_cyc.size() >= base_c + 100)
            chk("stream_out_no_bubble", out_cyc[base_c + 99] - out_cyc[base_c], 32'd99);
        else
            chk("stream_out_present", out_cyc.size() - base_c, 32'd100);

        // Random valid/ready toggling over 1000 words.
        base_n   = n_out;
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    in_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) step();
                    push_word($urandom(), 5'($urandom_range(0, 31)), w_tmp);
                end
                in_valid = 1'b0;
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    step();
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk("random_count", n_out - base_n, 32'd1000);
`ifdef ROT_FEEDER_COUNT_EN
        chk("count_1100", out_count, 32'd1100);

        // Saturation: push total output transfers past 65535.
        in_bits  = 32'h0F0F_0F0F;
        in_k     = 5'd8;
        in_valid = 1'b1;
        repeat (65540 - 1100 + 4) step();
        in_valid = 1'b0;
        drain();
        chk("count_saturated", out_count, 32'h0000_FFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
